clk_div_ctrl: RTL and testbench
===============================

Name: clk_div_ctrl

Overview:
- Run-time controller for the board's divided-clock generator.
- Owns the divide counter and sequences it through idle, free-run and single-step periods.
- Accepts new divisor values over a valid/ready handshake and applies them only at a period boundary, so `clock_out` never glitches.
- Feeds the display/ALU logic with both a square `clock_out` and a one-cycle `tick` enable.

Parameters:
- CNT_W, 28: counter and divisor width.
- DEFAULT_DIV, 20000: divisor loaded at reset.
- MIN_DIV, 2: smallest legal divisor; smaller writes are rejected.

Ports:
- clock_in  input  1  FPGA input clock, the only clock.
- reset_in  input  1  asynchronous, active-high reset.
- run  input  1  level; 1 = free-run periods.
- step  input  1  one-cycle pulse; request exactly one period while idle.
- div_wr_valid  input  1  divisor write request.
- div_wr_data  input  CNT_W  requested divisor.
- div_wr_ready  output  1  controller can accept a write.
- div_err  output  1  one-cycle pulse: write rejected (data < MIN_DIV).
- div_active  output  CNT_W  divisor currently in use.
- tick  output  1  one-cycle pulse per completed period.
- clock_out  output  1  divided square wave.
- state  output  2  0 = IDLE, 1 = RUN, 2 = STEP.

Behaviour:
- Reset (async, immediate):
  - counter = 0, `div_active` = DEFAULT_DIV, pending register empty.
  - `tick` = 0, `clock_out` = 0, `div_err` = 0, `div_wr_ready` = 1, `state` = IDLE.
  - Reset mid-period or mid-write discards everything, including the pending divisor.
- IDLE:
  - Counter held at 0; `clock_out` = 0; no ticks.
  - run = 1 -> RUN next cycle.
  - step = 1 with run = 0 -> STEP. If both are 1, RUN wins.
  - step while not IDLE is ignored.
- RUN / STEP counting:
  - Counter increments each cycle.
  - When counter == div_active-1 ("wrap") the counter goes to 0 next cycle.
  - `clock_out` is registered as (counter < div_active/2), using floor division. High for floor(D/2) cycles, low for ceil(D/2) cycles; first high cycle follows state entry.
  - `tick` is registered: high for the one cycle after the wrap cycle.
  - Counter never exceeds div_active-1; all compares are unsigned.
- RUN exit: evaluated only at wrap. run = 0 at wrap -> IDLE; deasserting run mid-period completes the period.
- STEP exit: at wrap -> IDLE, or -> RUN if run = 1 at that wrap. Exactly one tick is issued.
- Divisor write handshake:
  - Transfer occurs when div_wr_valid && div_wr_ready.
  - data < MIN_DIV: not stored; `div_err` = 1 next cycle; `div_wr_ready` stays 1.
  - Legal data goes into the pending register and `div_wr_ready` drops to 0 next cycle.
- Applying the pending divisor:
  - In IDLE: copied to `div_active` on the next cycle.
  - In RUN/STEP: copied at the next wrap, so the new period starts with the new divisor.
  - `div_wr_ready` returns to 1 the cycle after the copy.
  - A write accepted in the same cycle as a wrap is applied at the following wrap, not the current one.
- Max divisor 2^CNT_W - 1 is legal; no wrap-around overflow of the counter.

Decomposition:
- Package `clk_div_pkg`:
  - state encoding constants (ST_IDLE = 0, ST_RUN = 1, ST_STEP = 2);
  - CNT_W default;
  - MIN_DIV.
- One natural sub-module, `clk_div_core`:
  - contents: counter, `clock_out` and `tick` generation;
  - inputs: `enable`, divisor;
  - output: `wrap` strobe.
- `clk_div_ctrl` holds the FSM, pending register and handshake.

Test Plan (all scenarios use DEFAULT_DIV = 4):
- Reset, then run = 1 held:
  - `tick` every 4 cycles;
  - `clock_out` pattern 1,1,0,0 repeating;
  - `state` = 1.
- In IDLE, step pulse:
  - `state` = 2 for 4 cycles;
  - exactly one `tick`;
  - back to IDLE with `clock_out` = 0;
  - a second step while in STEP is ignored.
- RUN, write 6 mid-period:
  - current period stays 4 cycles, `div_wr_ready` = 0 until the wrap;
  - `div_active` = 6 after the wrap;
  - next ticks 6 cycles apart;
  - `clock_out` 1,1,1,0,0,0.
- Write 1:
  - `div_err` pulses once;
  - `div_active` stays 4;
  - `div_wr_ready` stays 1.
- Write 5 in IDLE: `div_active` = 5 within 2 cycles; then run = 1 gives `clock_out` 1,1,0,0,0.
- run dropped at counter = 1, then reset_in asserted mid-period:
  - the period completes and the block returns to IDLE;
  - reset clears all outputs in the same cycle (async);
  - `div_active` returns to 4.

Source files
------------

// File: rtl/clk_div_pkg.sv
// ----------------------------------------------------------------------------
// clk_div_pkg : shared types and defaults for the divided-clock controller
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clk_div_pkg;

  localparam int CNT_W_DFLT   = 28;
  localparam int MIN_DIV_DFLT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/clk_div_core.sv
// ----------------------------------------------------------------------------
// clk_div_core : divide counter with registered square output and period tick
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DFLT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CNT_W-1:0] div,
  output logic             wrap,
  output logic             tick,
  output logic             clock_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;

  // The counter stops at div-1, so the increment can never overflow even
  // for the largest representable divisor.
  always_comb begin
    wrap      = enable && (cnt_q == (div - CNT_W'(1)));
    cnt_d     = '0;
    if (enable && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d    = wrap;
    clk_out_d = enable && (cnt_q < (div >> 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      clk_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign tick      = tick_q;
  assign clock_out = clk_out_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// clk_div_ctrl : idle/run/step sequencing and glitch-free divisor updates
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DFLT,
  parameter int DEFAULT_DIV = 20000,
  parameter int MIN_DIV     = MIN_DIV_DFLT
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             run,
  input  logic             step,
  input  logic             div_wr_valid,
  input  logic [CNT_W-1:0] div_wr_data,
  output logic             div_wr_ready,
  output logic             div_err,
  output logic [CNT_W-1:0] div_active,
  output logic             tick,
  output logic             clock_out,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] c_min_div     = CNT_W'(MIN_DIV);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_active_q, div_active_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             div_err_q, div_err_d;

  logic             w_core_en;
  logic             w_wrap;
  logic             w_accept;
  logic             w_apply;

  assign w_core_en = (state_q != ST_IDLE);

  clk_div_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk       (clock_in),
    .rst       (reset_in),
    .enable    (w_core_en),
    .div       (div_active_q),
    .wrap      (w_wrap),
    .tick      (tick),
    .clock_out (clock_out)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run) begin
          state_d = ST_RUN;
        end else if (step) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (w_wrap && !run) begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (w_wrap) begin
          state_d = run ? ST_RUN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Only a divisor already sitting in the pending register can be applied,
  // so a write accepted on a wrap cycle waits for the following wrap.
  always_comb begin
    w_accept     = div_wr_valid && !pend_vld_q;
    w_apply      = pend_vld_q && ((state_q == ST_IDLE) || w_wrap);
    div_err_d    = w_accept && (div_wr_data < c_min_div);
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_vld_d   = pend_vld_q;
    if (w_apply) begin
      div_active_d = pend_q;
      pend_vld_d   = 1'b0;
    end else if (w_accept && !div_err_d) begin
      pend_d     = div_wr_data;
      pend_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q      <= ST_IDLE;
      div_active_q <= c_default_div;
      pend_q       <= '0;
      pend_vld_q   <= 1'b0;
      div_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      pend_vld_q   <= pend_vld_d;
      div_err_q    <= div_err_d;
    end
  end

  assign div_wr_ready = !pend_vld_q;
  assign div_err      = div_err_q;
  assign div_active   = div_active_q;
  assign state        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clk_div_ctrl : directed and random stimulus against a period-level model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_clk_div_ctrl;

  localparam int W = 28;

  logic         clk = 1'b0;
  logic         rst;
  logic         run, step, div_wr_valid;
  logic [W-1:0] div_wr_data;
  logic         div_wr_ready, div_err, tick, clock_out;
  logic [W-1:0] div_active;
  logic [1:0]   state;

  int nvec = 0;
  int nerr = 0;
  bit chk_on = 1'b0;

  clk_div_ctrl #(
    .CNT_W       (W),
    .DEFAULT_DIV (4),
    .MIN_DIV     (2)
  ) dut (
    .clock_in     (clk),
    .reset_in     (rst),
    .run          (run),
    .step         (step),
    .div_wr_valid (div_wr_valid),
    .div_wr_data  (div_wr_data),
    .div_wr_ready (div_wr_ready),
    .div_err      (div_err),
    .div_active   (div_active),
    .tick         (tick),
    .clock_out    (clock_out),
    .state        (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a mode, the position inside the current period, the
  // divisor governing that period and an optional queued divisor.
  int unsigned m_mode  = 0;
  int unsigned m_pos   = 0;
  int unsigned m_div   = 4;
  int unsigned m_pend  = 0;
  bit          m_pv    = 1'b0;
  bit          e_tick  = 1'b0;
  bit          e_clk   = 1'b0;
  bit          e_err   = 1'b0;
  bit          m_busy, m_last, m_acc;
  int unsigned m_next;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pos = 0; m_div = 4; m_pend = 0; m_pv = 1'b0;
      e_tick = 1'b0; e_clk = 1'b0; e_err = 1'b0;
    end else begin
      m_busy = (m_mode != 0);
      m_last = m_busy && (m_pos == m_div - 1);
      e_clk  = m_busy && (m_pos < m_div / 2);
      e_tick = m_last;
      m_acc  = div_wr_valid && !m_pv;
      e_err  = m_acc && (div_wr_data < 2);
      m_next = m_mode;
      if (m_mode == 0)       m_next = run ? 1 : (step ? 2 : 0);
      else if (m_last)       m_next = run ? 1 : 0;
      m_pos = (m_busy && !m_last) ? m_pos + 1 : 0;
      if (m_pv && (m_mode == 0 || m_last)) begin
        m_div = m_pend;
        m_pv  = 1'b0;
      end else if (m_acc && div_wr_data >= 2) begin
        m_pend = 32'(div_wr_data);
        m_pv   = 1'b1;
      end
      m_mode = m_next;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("state",  32'(state),        m_mode);
      chk("div",    32'(div_active),   m_div);
      chk("ready",  32'(div_wr_ready), 32'(!m_pv));
      chk("err",    32'(div_err),      32'(e_err));
      chk("tick",   32'(tick),         32'(e_tick));
      chk("clkout", 32'(clock_out),    32'(e_clk));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat_c, pat_t;
  int         n_st, n_tk, n_er;

  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b0; div_wr_valid = 1'b0; div_wr_data = '0;
    #2 rst = 1'b1;
    repeat (3) cyc();
    rst = 1'b0;
    chk_on = 1'b1;
    chk("rst_state", 32'(state), 0);
    chk("rst_div",   32'(div_active), 4);
    chk("rst_ready", 32'(div_wr_ready), 1);
    chk("rst_outs",  32'({tick, clock_out, div_err}), 0);

    // free run at the reset divisor
    run = 1'b1;
    cyc();
    chk("run_state", 32'(state), 1);
    for (int i = 0; i < 8; i++) begin
      cyc();
      pat_c = {pat_c[6:0], clock_out};
      pat_t = {pat_t[6:0], tick};
    end
    chk("run_clk_pat",  32'(pat_c), 32'h00CC);
    chk("run_tick_pat", 32'(pat_t), 32'h0011);
    run = 1'b0;
    repeat (6) cyc();
    chk("stop_state", 32'(state), 0);
    chk("stop_clk",   32'(clock_out), 0);

    // single step, with a second step request issued mid-step
    step = 1'b1;
    cyc();
    n_st = (state == 2'd2) ? 1 : 0;
    n_tk = int'(tick);
    for (int i = 0; i < 10; i++) begin
      step = (i == 1);
      cyc();
      n_st += (state == 2'd2) ? 1 : 0;
      n_tk += int'(tick);
    end
    step = 1'b0;
    chk("step_cycles", 32'(n_st), 4);
    chk("step_ticks",  32'(n_tk), 1);
    chk("step_end",    32'({state, clock_out}), 0);

    // illegal divisor
    div_wr_valid = 1'b1; div_wr_data = 28'd1;
    cyc();
    div_wr_valid = 1'b0;
    chk("err_pulse", 32'(div_err), 1);
    chk("err_ready", 32'(div_wr_ready), 1);
    n_er = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_er += int'(div_err);
    end
    chk("err_once", 32'(n_er), 1);
    chk("err_div",  32'(div_active), 4);

    // divisor 6 written mid-period while running
    run = 1'b1;
    cyc(); cyc();
    div_wr_valid = 1'b1; div_wr_data = 28'd6;
    cyc();
    div_wr_valid = 1'b0;
    chk("wr6_ready_lo", 32'(div_wr_ready), 0);
    cyc();
    chk("wr6_old_div", 32'(div_active), 4);
    chk("wr6_ready_lo2", 32'(div_wr_ready), 0);
    cyc();
    chk("wr6_tick", 32'(tick), 1);
    chk("wr6_div",  32'(div_active), 6);
    chk("wr6_ready_hi", 32'(div_wr_ready), 1);
    for (int i = 0; i < 6; i++) begin
      cyc();
      pat_c = {pat_c[6:0], clock_out};
      pat_t = {pat_t[6:0], tick};
    end
    chk("wr6_clk_pat",  32'(pat_c[5:0]), 32'h38);
    chk("wr6_tick_pat", 32'(pat_t[5:0]), 32'h01);
    run = 1'b0;
    repeat (8) cyc();
    chk("wr6_idle", 32'(state), 0);

    // divisor 5 written in idle, then run
    div_wr_valid = 1'b1; div_wr_data = 28'd5;
    cyc();
    div_wr_valid = 1'b0;
    cyc();
    chk("wr5_div", 32'(div_active), 5);
    run = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      cyc();
      pat_c = {pat_c[6:0], clock_out};
    end
    chk("wr5_clk_pat", 32'(pat_c[4:0]), 32'h18);

    // run dropped at counter 1: period still completes
    cyc();
    run = 1'b0;
    repeat (3) cyc();
    chk("drop_state_run", 32'(state), 1);
    cyc();
    chk("drop_tick", 32'(tick), 1);
    chk("drop_idle", 32'(state), 0);

    // async reset mid-period with a write pending
    run = 1'b1;
    cyc(); cyc();
    div_wr_valid = 1'b1; div_wr_data = 28'd9;
    cyc();
    div_wr_valid = 1'b0;
    run = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_state", 32'(state), 0);
    chk("arst_div",   32'(div_active), 4);
    chk("arst_ready", 32'(div_wr_ready), 1);
    chk("arst_outs",  32'({tick, clock_out, div_err}), 0);
    cyc();
    rst = 1'b0;
    repeat (12) cyc();
    chk("arst_pend_gone", 32'(div_active), 4);

    // largest divisor is accepted
    div_wr_valid = 1'b1; div_wr_data = {W{1'b1}};
    cyc();
    div_wr_valid = 1'b0;
    cyc();
    chk("max_div", 32'(div_active), 32'h0FFF_FFFF);
    rst = 1'b1;
    cyc();
    rst = 1'b0;

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) run = ~run;
      step         = ($urandom_range(0, 7) == 0);
      div_wr_valid = ($urandom_range(0, 5) == 0);
      div_wr_data  = W'($urandom_range(0, 9));
      if ($urandom_range(0, 599) == 0) rst = 1'b1;
      cyc();
      rst = 1'b0;
    end
    run = 1'b0; step = 1'b0; div_wr_valid = 1'b0;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire
